// File: rtl/rex_game_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rex_game_ctrl_if : control inputs and status outputs of the game sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
interface rex_game_ctrl_if #(
    parameter int Y_W     = 8,
    parameter int SCORE_W = 14
) ();
    logic               tick;
    logic               Start;
    logic               Jump;
    logic               Duck;
    logic               Pause;
    logic               collision;
    logic               q_Init;
    logic               q_Run;
    logic               q_Jump;
    logic               q_Duck;
    logic               q_Pause;
    logic               q_Stop;
    logic [Y_W-1:0]     rex_y;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] hi_score;
    logic [2:0]         speed_lvl;

    modport master (
        output tick, Start, Jump, Duck, Pause, collision,
        input  q_Init, q_Run, q_Jump, q_Duck, q_Pause, q_Stop,
        input  rex_y, score, hi_score, speed_lvl
    );

    modport slave (
        input  tick, Start, Jump, Duck, Pause, collision,
        output q_Init, q_Run, q_Jump, q_Duck, q_Pause, q_Stop,
        output rex_y, score, hi_score, speed_lvl
    );
endinterface
`default_nettype wire

// File: rtl/rex_game_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rex_game_ctrl : game-state sequencer (jump physics, score, speed level)
// Rev 1.0
// ---------------------------------------------------------------------------
module rex_game_ctrl #(
    parameter int JUMP_V0    = 12,
    parameter int GRAVITY    = 1,
    parameter int Y_W        = 8,
    parameter int SCORE_W    = 14,
    parameter int SPEED_STEP = 100
) (
    input  wire             ClkPort,
    input  wire             Reset_n,
    rex_game_ctrl_if.slave  bus
);
    localparam int                 SUB_W       = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;
    localparam logic [SCORE_W-1:0] c_SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [SUB_W-1:0]   c_SUB_LAST  = SUB_W'(SPEED_STEP - 1);
    localparam logic [2:0]         c_SPEED_MAX = 3'd7;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_RUN   = 3'd1,
        S_JUMP  = 3'd2,
        S_DUCK  = 3'd3,
        S_PAUSE = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    state_t                 r_saved;
    state_t                 w_saved_nxt;

    logic [Y_W-1:0]         r_rex_y;
    logic signed [Y_W-1:0]  r_vel;
    logic [SCORE_W-1:0]     r_score;
    logic [SCORE_W-1:0]     r_hi;
    logic [SUB_W-1:0]       r_sub;
    logic                   r_bump;
    logic [2:0]             r_speed;

    logic signed [Y_W+1:0]  w_sum;
    logic                   w_landed;
    logic                   w_clear;
    logic                   w_score_adv;
    logic                   w_score_inc;
    logic                   w_launch;
    logic                   w_fly;
    logic                   w_land;

    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_INIT;
            r_saved <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
            r_saved <= w_saved_nxt;
        end
    end

    // Collision and Pause pre-empt the tick update so a frozen frame really is frozen.
    always_comb begin
        w_state_nxt = r_state;
        w_saved_nxt = r_saved;
        w_clear     = 1'b0;
        w_score_adv = 1'b0;
        w_launch    = 1'b0;
        w_fly       = 1'b0;
        w_land      = 1'b0;
        w_sum       = $signed({2'b00, r_rex_y}) + $signed({{2{r_vel[Y_W-1]}}, r_vel});
        w_landed    = w_sum[Y_W+1] || (w_sum == '0);

        case (r_state)
            S_INIT: begin
                if (bus.Start) begin
                    w_state_nxt = S_RUN;
                    w_clear     = 1'b1;
                end
            end
            S_RUN, S_DUCK: begin
                if (bus.collision) begin
                    w_state_nxt = S_STOP;
                end else if (bus.Pause) begin
                    w_state_nxt = S_PAUSE;
                    w_saved_nxt = r_state;
                end else begin
                    w_score_adv = bus.tick;
                    if (bus.Jump) begin
                        w_state_nxt = S_JUMP;
                        w_launch    = 1'b1;
                    end else if (bus.Duck) begin
                        w_state_nxt = S_DUCK;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_JUMP: begin
                if (bus.collision) begin
                    w_state_nxt = S_STOP;
                end else if (bus.Pause) begin
                    w_state_nxt = S_PAUSE;
                    w_saved_nxt = S_JUMP;
                end else if (bus.tick) begin
                    w_score_adv = 1'b1;
                    if (w_landed) begin
                        w_land      = 1'b1;
                        w_state_nxt = bus.Duck ? S_DUCK : S_RUN;
                    end else begin
                        w_fly = 1'b1;
                    end
                end
            end
            S_PAUSE: begin
                if (bus.Start) begin
                    w_state_nxt = S_INIT;
                end else if (bus.Pause) begin
                    w_state_nxt = (r_saved == S_DUCK && !bus.Duck) ? S_RUN : r_saved;
                end
            end
            S_STOP: begin
                if (bus.Start) begin
                    w_state_nxt = S_RUN;
                    w_clear     = 1'b1;
                end
            end
            default: w_state_nxt = S_INIT;
        endcase

        w_score_inc = w_score_adv && (r_score != c_SCORE_MAX);
    end

    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rex_y <= '0;
            r_vel   <= '0;
            r_score <= '0;
            r_hi    <= '0;
            r_sub   <= '0;
            r_bump  <= 1'b0;
            r_speed <= '0;
        end else begin
            if (w_clear) begin
                r_rex_y <= '0;
                r_vel   <= '0;
            end else if (w_launch) begin
                r_vel   <= Y_W'(JUMP_V0);
            end else if (w_land) begin
                r_rex_y <= '0;
                r_vel   <= '0;
            end else if (w_fly) begin
                r_rex_y <= w_sum[Y_W-1:0];
                r_vel   <= r_vel - Y_W'(GRAVITY);
            end

            if (w_clear) begin
                r_score <= '0;
            end else if (w_score_inc) begin
                r_score <= r_score + 1'b1;
            end

            // Score is frozen throughout STOP, so this settles on the entry cycle.
            if (r_state == S_STOP && r_score > r_hi) begin
                r_hi <= r_score;
            end

            // Modulo sub-counter marks each SPEED_STEP boundary; level follows a cycle later.
            if (w_clear) begin
                r_sub  <= '0;
                r_bump <= 1'b0;
            end else begin
                r_bump <= w_score_inc && (r_sub == c_SUB_LAST);
                if (w_score_inc) begin
                    r_sub <= (r_sub == c_SUB_LAST) ? '0 : r_sub + 1'b1;
                end
            end

            if (w_clear) begin
                r_speed <= '0;
            end else if (r_bump && r_speed != c_SPEED_MAX) begin
                r_speed <= r_speed + 1'b1;
            end
        end
    end

    assign bus.q_Init    = (r_state == S_INIT);
    assign bus.q_Run     = (r_state == S_RUN);
    assign bus.q_Jump    = (r_state == S_JUMP);
    assign bus.q_Duck    = (r_state == S_DUCK);
    assign bus.q_Pause   = (r_state == S_PAUSE);
    assign bus.q_Stop    = (r_state == S_STOP);
    assign bus.rex_y     = r_rex_y;
    assign bus.score     = r_score;
    assign bus.hi_score  = r_hi;
    assign bus.speed_lvl = r_speed;
endmodule
`default_nettype wire

// File: tb/tb_rex_game_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rex_game_ctrl : directed self-checking bench for rex_game_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_rex_game_ctrl;
    localparam int c_INIT  = 32'b100000;
    localparam int c_RUN   = 32'b010000;
    localparam int c_JUMP  = 32'b001000;
    localparam int c_DUCK  = 32'b000100;
    localparam int c_PAUSE = 32'b000010;
    localparam int c_STOP  = 32'b000001;
    localparam int c_JUMP_Y [25] = '{12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78, 78,
                                     77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 12, 0};

    logic clk;
    logic rst_n;
    logic duck;
    int   n_tests;
    int   n_fail;

    rex_game_ctrl_if #(.Y_W(8), .SCORE_W(14)) bus ();
    rex_game_ctrl_if #(.Y_W(8), .SCORE_W(4))  bus4 ();

    rex_game_ctrl #(
        .JUMP_V0(12), .GRAVITY(1), .Y_W(8), .SCORE_W(14), .SPEED_STEP(100)
    ) u_dut (
        .ClkPort (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    rex_game_ctrl #(
        .JUMP_V0(12), .GRAVITY(1), .Y_W(8), .SCORE_W(4), .SPEED_STEP(100)
    ) u_dut4 (
        .ClkPort (clk),
        .Reset_n (rst_n),
        .bus     (bus4)
    );

    assign bus4.tick      = bus.tick;
    assign bus4.Start     = bus.Start;
    assign bus4.Jump      = bus.Jump;
    assign bus4.Duck      = bus.Duck;
    assign bus4.Pause     = bus.Pause;
    assign bus4.collision = bus.collision;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int st_vec();
        return int'({bus.q_Init, bus.q_Run, bus.q_Jump, bus.q_Duck, bus.q_Pause, bus.q_Stop});
    endfunction

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs at a falling edge; returns at the next falling edge.
    task automatic step(input bit t, input bit st, input bit j, input bit p, input bit c);
        bus.tick      = t;
        bus.Start     = st;
        bus.Jump      = j;
        bus.Pause     = p;
        bus.collision = c;
        bus.Duck      = duck;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        duck    = 1'b0;
        bus.tick = 1'b0; bus.Start = 1'b0; bus.Jump = 1'b0;
        bus.Pause = 1'b0; bus.collision = 1'b0; bus.Duck = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        check_val("rst_state", st_vec(), c_INIT);
        check_val("rst_y", int'(bus.rex_y), 0);
        check_val("rst_score", int'(bus.score), 0);
        check_val("rst_hi", int'(bus.hi_score), 0);
        check_val("rst_speed", int'(bus.speed_lvl), 0);

        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check_val("init_ignore_state", st_vec(), c_INIT);
        check_val("init_ignore_score", int'(bus.score), 0);

        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("start_run", st_vec(), c_RUN);
        ticks(10);
        check_val("run10_score", int'(bus.score), 10);
        check_val("run10_y", int'(bus.rex_y), 0);

        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("jump_enter", st_vec(), c_JUMP);
        for (int k = 0; k < 25; k++) begin
            step(1'b1, 1'b0, (k == 4), 1'b0, 1'b0);
            check_val("jump_y", int'(bus.rex_y), c_JUMP_Y[k]);
            check_val("jump_state", st_vec(), (k < 24) ? c_JUMP : c_RUN);
        end
        check_val("jump_score", int'(bus.score), 35);

        duck = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("jump_duck_same", st_vec(), c_JUMP);
        ticks(25);
        check_val("land_duck", st_vec(), c_DUCK);
        check_val("land_duck_y", int'(bus.rex_y), 0);
        check_val("land_duck_score", int'(bus.score), 60);
        duck = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("duck_release", st_vec(), c_RUN);

        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(6);
        check_val("pause_pre_y", int'(bus.rex_y), 57);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("pause_enter", st_vec(), c_PAUSE);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b0, (i == 10));
        check_val("pause_hold_y", int'(bus.rex_y), 57);
        check_val("pause_hold_state", st_vec(), c_PAUSE);
        check_val("pause_hold_score", int'(bus.score), 66);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("resume_jump", st_vec(), c_JUMP);
        ticks(1);
        check_val("resume_y", int'(bus.rex_y), 63);
        ticks(18);
        check_val("resume_land", st_vec(), c_RUN);
        check_val("resume_land_y", int'(bus.rex_y), 0);
        check_val("resume_score", int'(bus.score), 85);
        check_val("sat4_score", int'(bus4.score), 15);

        ticks(14);
        check_val("speed_at99", int'(bus.speed_lvl), 0);
        ticks(1);
        check_val("speed_lag100", int'(bus.speed_lvl), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("speed_at100", int'(bus.speed_lvl), 1);
        ticks(150);
        check_val("score250", int'(bus.score), 250);
        check_val("speed_at250", int'(bus.speed_lvl), 2);
        check_val("sat4_hold", int'(bus4.score), 15);

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("collide_stop", st_vec(), c_STOP);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("hi_250", int'(bus.hi_score), 250);
        ticks(1);
        check_val("stop_frozen", int'(bus.score), 250);

        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("restart_run", st_vec(), c_RUN);
        check_val("restart_score", int'(bus.score), 0);
        check_val("restart_speed", int'(bus.speed_lvl), 0);
        check_val("restart_hi", int'(bus.hi_score), 250);
        ticks(40);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("stop40_score", int'(bus.score), 40);
        check_val("hi_kept", int'(bus.hi_score), 250);

        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 800; k++) begin
            ticks(1);
            if (k == 700) begin
                step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                check_val("speed_at700", int'(bus.speed_lvl), 7);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("score800", int'(bus.score), 800);
        check_val("speed_at800", int'(bus.speed_lvl), 7);

        duck = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("duck_enter", st_vec(), c_DUCK);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        duck = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("resume_duck_released", st_vec(), c_RUN);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("pause_abandon", st_vec(), c_INIT);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("init_restart_score", int'(bus.score), 0);

        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(5);
        check_val("midjump_y", int'(bus.rex_y), 50);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_state", st_vec(), c_INIT);
        check_val("async_y", int'(bus.rex_y), 0);
        check_val("async_score", int'(bus.score), 0);
        check_val("async_hi", int'(bus.hi_score), 0);
        check_val("async_speed", int'(bus.speed_lvl), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("post_rst_state", st_vec(), c_INIT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
